// File: rtl/tx_sample_serializer.sv
// tx_sample_serializer
// Buffers 16-bit samples in a small FIFO and feeds them, MSB byte first, to the
// UART byte transmitter using its active-low write strobe and byte_end pulse.
// Optional feature macro: TX_FRAME_SYNC_EN. When defined, a SYNC_BYTE is sent
// ahead of the first sample of every FRAME_LEN-sample frame.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | nothing in flight; leave when the FIFO is non-empty
// LOAD        | pop FIFO head into the holding register
// ISSUE_SYNC  | sync byte on tx_data; strobe once the transmitter is free
// WAIT_SYNC   | sync byte accepted; wait for byte_end
// ISSUE_HI    | MSB on tx_data; strobe once the transmitter is free
// WAIT_HI     | MSB accepted; wait for byte_end
// ISSUE_LO    | LSB on tx_data; strobe once the transmitter is free
// WAIT_LO     | LSB accepted; wait for byte_end, then back to IDLE
module tx_sample_serializer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int FRAME_LEN = 64,
    parameter int SYNC_BYTE = 8'hA5
) (
    input  logic          clk_50m,
    input  logic          rst,
    input  logic [15:0]   sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic [7:0]    tx_data,
    output logic          tx_wr_n,
    input  logic          tx_busy,
    input  logic          tx_byte_end,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic          idle
);

    // Parameter sanity checks at elaboration.
    if (DEPTH != (1 << AW)) begin : g_chk_depth
        $error("DEPTH must equal 2**AW");
    end
    if (FRAME_LEN < 1) begin : g_chk_frame
        $error("FRAME_LEN must be at least 1");
    end
    if ((SYNC_BYTE < 0) || (SYNC_BYTE > 255)) begin : g_chk_sync
        $error("SYNC_BYTE must fit in 8 bits");
    end

`ifdef TX_FRAME_SYNC_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE_HI, S_WAIT_HI, S_ISSUE_LO, S_WAIT_LO,
        S_ISSUE_SYNC, S_WAIT_SYNC
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE_HI, S_WAIT_HI, S_ISSUE_LO, S_WAIT_LO
    } state_t;
`endif

    state_t          state, state_nxt;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [15:0]     hold;
    logic [15:0]     head;
    logic [7:0]      tx_data_nxt;
    logic            full, empty, push, pop;

    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign push         = sample_valid && !full;
    // LOAD is only entered with a non-empty FIFO, so the pop is always legal.
    assign pop          = (state == S_LOAD);
    assign head         = mem[rd_ptr];
    assign sample_ready = !full;
    assign fifo_count   = count;
    assign idle         = (state == S_IDLE) && empty;

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk_50m) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (sample_valid && full) overflow <= 1'b1;
        end
    end

`ifdef TX_FRAME_SYNC_EN
    localparam int         FC_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [7:0] SYNC_VAL = SYNC_BYTE[7:0];
    logic [FC_W-1:0] frame_cnt;

    // Frame position, advanced once per sample loaded.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state == S_LOAD) begin
            if (frame_cnt == FC_W'(FRAME_LEN - 1)) frame_cnt <= '0;
            else                                   frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

    // State, registered tx_data and holding register.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            tx_data <= '0;
            hold    <= '0;
        end else begin
            state   <= state_nxt;
            tx_data <= tx_data_nxt;
            if (state == S_LOAD) hold <= head;
        end
    end

    // Next-state, next tx_data and the write strobe.
    always_comb begin
        state_nxt   = state;
        tx_data_nxt = tx_data;
        tx_wr_n     = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt   = S_ISSUE_HI;
                tx_data_nxt = head[15:8];
`ifdef TX_FRAME_SYNC_EN
                if (frame_cnt == '0) begin
                    state_nxt   = S_ISSUE_SYNC;
                    tx_data_nxt = SYNC_VAL;
                end
`endif
            end
            S_ISSUE_HI: begin
                if (!tx_busy) begin
                    tx_wr_n   = 1'b0;
                    state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_byte_end) begin
                    state_nxt   = S_ISSUE_LO;
                    tx_data_nxt = hold[7:0];
                end
            end
            S_ISSUE_LO: begin
                if (!tx_busy) begin
                    tx_wr_n   = 1'b0;
                    state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (tx_byte_end) state_nxt = S_IDLE;
            end
`ifdef TX_FRAME_SYNC_EN
            S_ISSUE_SYNC: begin
                if (!tx_busy) begin
                    tx_wr_n   = 1'b0;
                    state_nxt = S_WAIT_SYNC;
                end
            end
            S_WAIT_SYNC: begin
                if (tx_byte_end) begin
                    state_nxt   = S_ISSUE_HI;
                    tx_data_nxt = hold[15:8];
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_sample_serializer.sv
// Testbench for tx_sample_serializer: UART transmitter model plus a byte-stream
// reference model built from the sample order and the frame-sync rule.
module tb_tx_sample_serializer;

    localparam int         DEPTH     = 16;
    localparam int         AW        = 4;
    localparam int         FRAME_LEN = 2;
    localparam logic [7:0] SYNC      = 8'hA5;
`ifdef TX_FRAME_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    logic          clk_50m = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [7:0]    tx_data;
    logic          tx_wr_n;
    logic          tx_busy;
    logic          tx_byte_end;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          idle;

    logic force_busy = 1'b0, inject_be = 1'b0;
    logic model_busy = 1'b0, model_be = 1'b0;
    int   model_timer = 0;
    int   since_be = 0, wr_count = 0, viol = 0;

    int total = 0, bad = 0;
    int frame_idx = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         exp_kind[$];   // 0 sync, 1 msb, 2 lsb
    int         gap_q[$];

    assign tx_busy     = force_busy | model_busy;
    assign tx_byte_end = model_be | inject_be;

    tx_sample_serializer #(
        .DEPTH(DEPTH), .AW(AW), .FRAME_LEN(FRAME_LEN), .SYNC_BYTE(int'(SYNC))
    ) dut (
        .clk_50m(clk_50m), .rst(rst), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .tx_data(tx_data), .tx_wr_n(tx_wr_n), .tx_busy(tx_busy),
        .tx_byte_end(tx_byte_end), .fifo_count(fifo_count),
        .overflow(overflow), .idle(idle)
    );

    always #10 clk_50m = ~clk_50m;

    // Transmitter model: busy from the cycle after the strobe, byte_end ~20 cycles on.
    always @(posedge clk_50m) begin
        model_be <= 1'b0;
        if (!tx_wr_n) begin
            wr_count <= wr_count + 1;
            got_q.push_back(tx_data);
            gap_q.push_back(since_be);
            if (tx_busy) viol <= viol + 1;
            else begin
                model_busy  <= 1'b1;
                model_timer <= 19;
            end
        end else if (model_timer > 0) begin
            model_timer <= model_timer - 1;
            if (model_timer == 1) begin
                model_be   <= 1'b1;
                model_busy <= 1'b0;
            end
        end
        if (tx_byte_end) since_be <= 0;
        else             since_be <= since_be + 1;
    end

    task automatic model_push(input logic [15:0] s);
        if (SYNC_ON && frame_idx == 0) begin
            exp_q.push_back(SYNC); exp_kind.push_back(0);
        end
        exp_q.push_back(s[15:8]); exp_kind.push_back(1);
        exp_q.push_back(s[7:0]);  exp_kind.push_back(2);
        if (SYNC_ON) frame_idx = (frame_idx + 1) % FRAME_LEN;
    endtask

    task automatic clear_q();
        got_q.delete(); exp_q.delete(); exp_kind.delete(); gap_q.delete();
    endtask

    task automatic push_one(input logic [15:0] s);
        sample_in = s; sample_valid = 1'b1;
        @(negedge clk_50m);
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit to);
        int n = 0;
        to = 1'b0;
        while (!(idle && !tx_busy && got_q.size() >= exp_q.size())) begin
            @(negedge clk_50m);
            n++;
            if (n > 6000) begin to = 1'b1; break; end
        end
        repeat (5) @(negedge clk_50m);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_50m);
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", sample_ready); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        total++; if (tx_wr_n !== 1'b1) begin bad++; $display("FAIL rst_wr_n: got %b want 1", tx_wr_n); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
        rst = 1'b0;
        frame_idx = 0;
        clear_q();
        @(negedge clk_50m);
    endtask

    task automatic test_single();
        bit to;
        int k;
        clear_q();
        sample_in = 16'h1234; sample_valid = 1'b1;
        model_push(16'h1234);
        for (k = 1; k <= 10; k++) begin
            @(negedge clk_50m);
            sample_valid = 1'b0;
            if (!tx_wr_n) break;
        end
        total++; if (k != 3) begin bad++; $display("FAIL t1_latency: got %0d cycles want 3", k); end
        total++; if (tx_data !== exp_q[0]) begin bad++; $display("FAIL t1_first_byte: got %h want %h", tx_data, exp_q[0]); end
        wait_drain(to);
        total++; if (to) begin bad++; $display("FAIL t1_drain: timed out got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t1_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t1_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL t1_idle: got %b want 1", idle); end
    endtask

    task automatic test_random();
        bit to;
        int n;
        logic [15:0] s;
        clear_q();
        n = $urandom_range(10, 4);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(30, 0)) @(negedge clk_50m);
            s = 16'($urandom());
            model_push(s);
            push_one(s);
        end
        wait_drain(to);
        total++; if (to) begin bad++; $display("FAIL rnd_drain: timed out got %0d want %0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rnd_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [15:0] s;
        int want;
        clear_q();
        for (int i = 0; i < 3; i++) begin
            s = 16'($urandom());
            model_push(s);
            push_one(s);
        end
        wait_drain(to);
        total++; if (to) begin bad++; $display("FAIL b2b_drain: timed out got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        // After an LSB the FSM passes IDLE and LOAD; otherwise the next strobe follows immediately.
        for (int i = 1; i < exp_kind.size() && i < gap_q.size(); i++) begin
            want = (exp_kind[i-1] == 2) ? 2 : 0;
            total++; if (gap_q[i] != want) begin bad++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, gap_q[i], want); end
        end
    endtask

    task automatic test_idle_byte_end();
        int wc;
        wc = wr_count;
        inject_be = 1'b1;
        @(negedge clk_50m);
        inject_be = 1'b0;
        repeat (10) @(negedge clk_50m);
        total++; if (wr_count != wc) begin bad++; $display("FAIL t6_wr: got %0d strobes want %0d", wr_count, wc); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL t6_idle: got %b want 1", idle); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL t6_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_overflow();
        logic [15:0] s;
        clear_q();
        force_busy = 1'b1;
        s = 16'($urandom());
        model_push(s);
        push_one(s);
        repeat (4) @(negedge clk_50m);
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL t2_loaded: got %0d want 0", fifo_count); end
        for (int i = 0; i < DEPTH + 2; i++) begin
            s = 16'($urandom());
            sample_in = s; sample_valid = 1'b1;
            if (i < DEPTH) model_push(s);
            @(negedge clk_50m);
            if (i == DEPTH - 2) begin
                total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL t2_ready15: got %b want 1", sample_ready); end
            end
            if (i == DEPTH - 1) begin
                total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL t2_ready16: got %b want 0", sample_ready); end
            end
        end
        sample_valid = 1'b0;
        total++; if (fifo_count !== (AW+1)'(DEPTH)) begin bad++; $display("FAIL t2_count: got %0d want %0d", fifo_count, DEPTH); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t2_overflow: got %b want 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        bit to, found;
        logic prev_ready;
        logic [15:0] v;
        v = 16'($urandom());
        found = 1'b0;
        prev_ready = sample_ready;
        sample_in = v; sample_valid = 1'b1;
        force_busy = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_50m);
            if (fifo_count == (AW+1)'(DEPTH - 1)) begin found = 1'b1; break; end
            prev_ready = sample_ready;
        end
        total++; if (!found) begin bad++; $display("FAIL t3_pop: count never reached %0d, got %0d", DEPTH - 1, fifo_count); end
        total++; if (prev_ready !== 1'b0) begin bad++; $display("FAIL t3_refused: ready was %b want 0", prev_ready); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL t3_ready: got %b want 1", sample_ready); end
        @(negedge clk_50m);
        sample_valid = 1'b0;
        model_push(v);
        total++; if (fifo_count !== (AW+1)'(DEPTH)) begin bad++; $display("FAIL t3_refill: got %0d want %0d", fifo_count, DEPTH); end
        wait_drain(to);
        total++; if (to) begin bad++; $display("FAIL t3_drain: timed out got %0d want %0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t3_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t3_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t3_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid_byte();
        bit to;
        int n, early;
        logic [15:0] s;
        clear_q();
        s = 16'($urandom());
        model_push(s);
        push_one(s);
        n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin @(negedge clk_50m); n++; end
        repeat (3) @(negedge clk_50m);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t4_pre_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t4_pre_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        push_one(16'($urandom()));
        rst = 1'b1; force_busy = 1'b1;
        @(negedge clk_50m);
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL t4_ready: got %b want 1", sample_ready); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL t4_tx_data: got %h want 00", tx_data); end
        total++; if (tx_wr_n !== 1'b1) begin bad++; $display("FAIL t4_wr_n: got %b want 1", tx_wr_n); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL t4_count: got %0d want 0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t4_overflow: got %b want 0", overflow); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL t4_idle: got %b want 1", idle); end
        rst = 1'b0;
        clear_q();
        frame_idx = 0;
        s = 16'($urandom());
        model_push(s);
        push_one(s);
        early = 0;
        repeat (9) begin
            @(negedge clk_50m);
            if (!tx_wr_n) early++;
        end
        force_busy = 1'b0;
        total++; if (early != 0) begin bad++; $display("FAIL t4_early_wr: got %0d strobes want 0", early); end
        wait_drain(to);
        total++; if (to) begin bad++; $display("FAIL t4_drain: timed out got %0d want %0d", got_q.size(), exp_q.size()); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t4_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t4_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #1;
        @(negedge clk_50m);
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_idle_byte_end();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_byte();
        test_random();
        total++; if (viol != 0) begin bad++; $display("FAIL strobe_while_busy: got %0d want 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
